reg_file_sync: RTL and testbench
================================

# reg_file_sync

Synchronous, parametrised multi-port register file for the CPU datapath: one write port and two independent read ports, registered read data, write-to-read forwarding, and a hardware clear sequencer that zeroes every entry after reset or on request. It supersedes the 4x8 combinational register RAM. There are no latches and no tri-state outputs. The two read ports feed the ALU operand muxes, so both operands are fetched in one cycle.

## Interface
Parameters:
- DATA_W, 8, width of each register entry in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- en_in  input  1  port enable; low blocks reads and writes for that cycle
- we_in  input  1  write request, qualified by en_in
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr_a  input  ADDR_W  read port A address
- raddr_b  input  ADDR_W  read port B address
- clr_in  input  1  pulse request to zero all entries
- rdata_a  output  DATA_W  registered read data, port A
- rdata_b  output  DATA_W  registered read data, port B
- rvalid  output  1  rdata_a/rdata_b updated by the read issued in the previous cycle
- busy  output  1  clear sequence in progress; requests ignored

## Operation
- Storage: DEPTH x DATA_W flops. Reads never see X after the clear completes.
- FSM has two states: CLEAR and IDLE. A clear pointer clr_ptr (ADDR_W bits) drives the CLEAR state.
- CLEAR: each edge writes 0 to entry clr_ptr, then clr_ptr increments. The edge that clears entry DEPTH-1 moves to IDLE and returns clr_ptr to 0 (wrap).
- In CLEAR, en_in, we_in and reads are ignored. rvalid=0, busy=1, and rdata_a/rdata_b hold their value.
- IDLE, en_in=1: read issued on both ports every cycle. A write occurs if we_in=1.
- IDLE, en_in=0: no write. rdata_a/rdata_b hold, and rvalid=0 next cycle.
- Forwarding (write-first): if a write and a read target the same address in the same cycle, that port returns wdata, not the old contents. This applies independently per port; both ports may forward.
- Both read ports may address the same entry; both return identical data.
- clr_in=1 in IDLE: that edge performs no write and no read (rvalid=0 next cycle), and the FSM enters CLEAR with clr_ptr=0.
- clr_in in CLEAR is ignored; the sweep does not restart.
- Reset (rst_n=0 at an edge) has priority over everything:
  - State goes to CLEAR with clr_ptr=0.
  - rdata_a=0, rdata_b=0, rvalid=0, busy=1.
  - Storage contents are not reset directly; the sweep zeroes them.
  - Reset applied mid-sweep restarts the sweep from entry 0.

## Timing
- Reset values: rdata_a=0, rdata_b=0, rvalid=0, busy=1, state=CLEAR, clr_ptr=0.
- Clear duration: exactly DEPTH edges with rst_n=1 after reset release. busy falls after the DEPTH-th edge, so the first accepted request is in cycle DEPTH+1. Default DEPTH=4, so requests are accepted from the 5th cycle.
- clr_in sampled at edge N: busy=1 from N to N+DEPTH, and requests are accepted again at edge N+DEPTH+1.
- Read latency: 1 cycle. Addresses are sampled at edge N; data and rvalid=1 are visible after edge N, stable until edge N+1.
- Write latency: 0 cycles to storage. wdata sampled at edge N is readable by a read issued at edge N (forwarded) or any later edge.
- busy is a registered output with no combinational path from inputs. rdata and rvalid are registered.
- Back-to-back reads and writes sustain one per cycle with no bubbles.

## Test plan
- Reset/clear: hold rst_n=0 2 cycles, release; busy=1 for exactly 4 cycles, then 0. Reads of addresses 0..3 return 0x00, rvalid=1 one cycle after issue.
- Write/readback: write 0xA5->1, 0x3C->2; next cycle raddr_a=1, raddr_b=2 gives rdata_a=0xA5, rdata_b=0x3C, rvalid=1.
- Forwarding: entry 3 holds 0x11; same cycle write 0x7E->3 with raddr_a=3, raddr_b=3 gives both outputs 0x7E. A repeat read gives 0x7E.
- Enable/hold: with rdata_a=0xA5, drive en_in=0, we_in=1, wdata=0xFF->1; rvalid=0, rdata_a stays 0xA5, and a later read of 1 returns 0xA5.
- clr_in with a concurrent write of 0x55->0: the write is dropped, busy=1 for 4 cycles, a second clr_in mid-sweep does not extend busy, and all entries read 0x00 afterwards.
- Reset mid-sweep: assert rst_n=0 at sweep step 2, release; busy=1 for a full 4 cycles, and all entries read 0x00. Repeat with DATA_W=16, ADDR_W=3: busy lasts 8 cycles, and 0xBEEF->7 reads back 0xBEEF.

Source files
------------

// File: rtl/reg_file_sync.sv
// Multi-port register file: one write port, two registered read ports with write-first forwarding.
// A clear sequencer sweeps every entry to zero after reset or on a clr_in request.
module reg_file_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              clr_in,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        r_state_next;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] r_clr_ptr_next;
    logic              r_busy;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_write;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // clr_in outranks en_in: a clear request edge neither reads nor writes.
    assign w_accept = (r_state == ST_IDLE) && !clr_in && en_in;
    assign w_write  = w_accept && we_in;

    assign w_rd_a = (w_write && (waddr == raddr_a)) ? wdata : r_mem[raddr_a];
    assign w_rd_b = (w_write && (waddr == raddr_b)) ? wdata : r_mem[raddr_b];

    always_comb begin
        r_state_next   = r_state;
        r_clr_ptr_next = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    r_state_next   = ST_IDLE;
                    r_clr_ptr_next = '0;
                end else begin
                    r_clr_ptr_next = r_clr_ptr + ADDR_W'(1);
                end
            end
            default: begin
                if (clr_in) begin
                    r_state_next   = ST_CLEAR;
                    r_clr_ptr_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_state   <= r_state_next;
            r_clr_ptr <= r_clr_ptr_next;
            r_busy    <= (r_state_next == ST_CLEAR);
            r_rvalid  <= w_accept;
            if (w_accept) begin
                r_rdata_a <= w_rd_a;
                r_rdata_b <= w_rd_b;
            end
        end
    end

    // Storage has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_write) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign rvalid  = r_rvalid;
    assign busy    = r_busy;
endmodule

// File: tb/tb_reg_file_sync.sv
// Scoreboard bench for reg_file_sync: default 8x4 instance plus a 16x8 instance.
// Stimulus pushes expected read data; per-instance monitors pop on rvalid.
module tb_reg_file_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- small instance (DATA_W=8, ADDR_W=2)
    logic       rst_n, en_in, we_in, clr_in;
    logic [1:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata, rdata_a, rdata_b;
    logic       rvalid, busy;
    logic [15:0] q_s[$];

    reg_file_sync #(.DATA_W(8), .ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .we_in(we_in),
        .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .clr_in(clr_in), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid(rvalid), .busy(busy)
    );

    // ---------------- large instance (DATA_W=16, ADDR_W=3)
    logic        b_rst_n, b_en_in, b_we_in, b_clr_in;
    logic [2:0]  b_waddr, b_raddr_a, b_raddr_b;
    logic [15:0] b_wdata, b_rdata_a, b_rdata_b;
    logic        b_rvalid, b_busy;
    logic [31:0] q_b[$];

    reg_file_sync #(.DATA_W(16), .ADDR_W(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en_in(b_en_in), .we_in(b_we_in),
        .waddr(b_waddr), .wdata(b_wdata), .raddr_a(b_raddr_a), .raddr_b(b_raddr_b),
        .clr_in(b_clr_in), .rdata_a(b_rdata_a), .rdata_b(b_rdata_b),
        .rvalid(b_rvalid), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: one line per completed read transaction.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                logic [15:0] e;
                e = q_s.pop_front();
                $display("[TB] s read a=0x%02h b=0x%02h exp a=0x%02h b=0x%02h",
                         rdata_a, rdata_b, e[15:8], e[7:0]);
                check("s_read", {16'd0, rdata_a, rdata_b}, {16'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (b_rvalid === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_rvalid", 32'(b_rvalid), 32'd0);
            end else begin
                logic [31:0] e;
                e = q_b.pop_front();
                $display("[TB] b read a=0x%04h b=0x%04h exp a=0x%04h b=0x%04h",
                         b_rdata_a, b_rdata_b, e[31:16], e[15:0]);
                check("b_read", {b_rdata_a, b_rdata_b}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the small port; a read expectation is queued when a read is issued.
    task automatic op(input logic en, input logic we, input logic clr,
                      input logic [1:0] wa, input logic [7:0] wd,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic [7:0] ea, input logic [7:0] eb);
        en_in = en; we_in = we; clr_in = clr;
        waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        if (en && !clr) q_s.push_back({ea, eb});
        tick();
    endtask

    task automatic bop(input logic en, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] ea, input logic [15:0] eb);
        b_en_in = en; b_we_in = we; b_clr_in = 1'b0;
        b_waddr = wa; b_wdata = wd; b_raddr_a = ra; b_raddr_b = rb;
        if (en) q_b.push_back({ea, eb});
        tick();
    endtask

    // Counts edges until busy drops; the cap keeps a stuck design from hanging the run.
    task automatic wait_idle_s(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < 50);
    endtask

    task automatic wait_idle_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (b_busy !== 1'b0 && n < 50);
    endtask

    int n;

    initial begin
        rst_n = 1'b0; en_in = 1'b0; we_in = 1'b0; clr_in = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        b_rst_n = 1'b0; b_en_in = 1'b0; b_we_in = 1'b0; b_clr_in = 1'b0;
        b_waddr = '0; b_wdata = '0; b_raddr_a = '0; b_raddr_b = '0;

        // Reset and initial sweep
        tick(); tick();
        check("rst_rdata_a", 32'(rdata_a), 32'h0);
        check("rst_rdata_b", 32'(rdata_b), 32'h0);
        check("rst_rvalid",  32'(rvalid),  32'h0);
        check("rst_busy",    32'(busy),    32'h1);
        rst_n = 1'b1;
        wait_idle_s(n);
        check("init_busy_cycles", 32'(n), 32'd4);
        op(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        op(1, 0, 0, 0, 8'h00, 2, 3, 8'h00, 8'h00);

        // Write and readback
        op(1, 1, 0, 1, 8'hA5, 0, 0, 8'h00, 8'h00);
        op(1, 1, 0, 2, 8'h3C, 0, 0, 8'h00, 8'h00);
        op(1, 0, 0, 0, 8'h00, 1, 2, 8'hA5, 8'h3C);

        // Forwarding on both ports
        op(1, 1, 0, 3, 8'h11, 0, 0, 8'h00, 8'h00);
        op(1, 1, 0, 3, 8'h7E, 3, 3, 8'h7E, 8'h7E);
        op(1, 0, 0, 0, 8'h00, 3, 3, 8'h7E, 8'h7E);

        // Enable low blocks the write and holds read data
        op(1, 0, 0, 0, 8'h00, 1, 2, 8'hA5, 8'h3C);
        op(0, 1, 0, 1, 8'hFF, 1, 1, 8'h00, 8'h00);
        check("hold_rvalid",  32'(rvalid),  32'h0);
        check("hold_rdata_a", 32'(rdata_a), 32'hA5);
        op(1, 0, 0, 0, 8'h00, 1, 1, 8'hA5, 8'hA5);

        // clr_in with a concurrent write; second clr_in and writes mid-sweep are ignored
        op(1, 1, 1, 0, 8'h55, 1, 1, 8'h00, 8'h00);
        check("clr_busy",   32'(busy),   32'h1);
        check("clr_rvalid", 32'(rvalid), 32'h0);
        en_in = 1'b1; we_in = 1'b1; waddr = 2'd2; wdata = 8'hEE;
        n = 0;
        do begin
            clr_in = (n == 1);
            tick();
            n++;
        end while (busy !== 1'b0 && n < 50);
        check("clr_busy_cycles", 32'(n), 32'd4);
        op(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        op(1, 0, 0, 0, 8'h00, 2, 3, 8'h00, 8'h00);

        // Reset in the middle of a sweep restarts it
        op(1, 1, 0, 0, 8'h12, 3, 3, 8'h00, 8'h00);
        op(1, 1, 0, 1, 8'h34, 3, 3, 8'h00, 8'h00);
        op(1, 1, 0, 2, 8'h56, 3, 3, 8'h00, 8'h00);
        op(1, 1, 0, 3, 8'h78, 0, 1, 8'h12, 8'h34);
        op(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        op(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        wait_idle_s(n);
        check("midrst_busy_cycles", 32'(n), 32'd4);
        op(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        op(1, 0, 0, 0, 8'h00, 2, 3, 8'h00, 8'h00);
        op(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);

        // Wide/deep instance
        b_rst_n = 1'b1;
        wait_idle_b(n);
        check("b_busy_cycles", 32'(n), 32'd8);
        bop(1, 1, 7, 16'hBEEF, 0, 0, 16'h0000, 16'h0000);
        bop(1, 0, 0, 16'h0000, 7, 6, 16'hBEEF, 16'h0000);
        bop(1, 0, 0, 16'h0000, 6, 7, 16'h0000, 16'hBEEF);
        bop(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);

        tick(); tick();
        check("s_queue_drained", 32'(q_s.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
